// File: rtl/alu_rs_scheduler_pkg.sv
// alu_rs_scheduler_pkg: shared ALU op codes, default tag/op widths and boolean constants
package alu_rs_scheduler_pkg;
  localparam int TAG_W = 4;
  localparam int OP_W = 4;
  localparam logic True = 1'b1;
  localparam logic False = 1'b0;
  typedef enum logic [OP_W-1:0] {
    Add, Minus, Less_S, Less_U, And, Or, Xor, Sll, Srl, Sra, Eq, Ne
  } alu_op_e;
endpackage

// File: rtl/alu_rs_scheduler_lowest_one.sv
// rs_lowest_one: priority encoder; vec_i in, found_o = any bit set, idx_o = lowest set bit index
module rs_lowest_one #(
  parameter int N = 8
) (
  input  logic [N-1:0]         vec_i,
  output logic                 found_o,
  output logic [$clog2(N)-1:0] idx_o
);
  localparam int W = $clog2(N);
  always_comb begin
    found_o = |vec_i;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) if (vec_i[i]) idx_o = W'(i);
  end
endmodule

// File: rtl/alu_rs_scheduler.sv
// alu_rs_scheduler: ALU reservation station; dispatch in (issue_*), CDB wakeup (cdb_*), ALU request (alu_*), held result out (out_*)
module alu_rs_scheduler #(
  parameter int RS_SIZE = 8,
  parameter int TAG_W = alu_rs_scheduler_pkg::TAG_W,
  parameter int OP_W = alu_rs_scheduler_pkg::OP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clear,
  input  logic             issue_valid,
  input  logic [OP_W-1:0]  issue_op,
  input  logic [31:0]      issue_vj,
  input  logic [31:0]      issue_vk,
  input  logic             issue_qj_wait,
  input  logic             issue_qk_wait,
  input  logic [TAG_W-1:0] issue_qj,
  input  logic [TAG_W-1:0] issue_qk,
  input  logic [TAG_W-1:0] issue_dest,
  output logic             full,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  output logic             alu_ready,
  output logic [OP_W-1:0]  alu_op,
  output logic [31:0]      alu_lv,
  output logic [31:0]      alu_rv,
  input  logic [31:0]      alu_result,
  input  logic             alu_success,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output logic [31:0]      out_value,
  input  logic             out_grant
);
  import alu_rs_scheduler_pkg::*;
  localparam int IW = $clog2(RS_SIZE);
  typedef struct packed {
    logic             valid;
    logic [OP_W-1:0]  op;
    logic [31:0]      vj;
    logic [31:0]      vk;
    logic             wj;
    logic             wk;
    logic [TAG_W-1:0] qj;
    logic [TAG_W-1:0] qk;
    logic [TAG_W-1:0] dest;
  } ent_t;
  ent_t ent_q [RS_SIZE];
  ent_t ent_d [RS_SIZE];
  logic [RS_SIZE-1:0] vld, elig;
  logic free_found, pick_found, sel, done, disp, byp_j, byp_k;
  logic [IW-1:0] free_idx, pick_idx;
  logic out_valid_q, out_valid_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic [31:0] out_value_q, out_value_d;
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      vld[i] = ent_q[i].valid;
      elig[i] = ent_q[i].valid && !ent_q[i].wj && !ent_q[i].wk;
    end
  end
  rs_lowest_one #(.N(RS_SIZE)) u_free (.vec_i(~vld), .found_o(free_found), .idx_o(free_idx));
  rs_lowest_one #(.N(RS_SIZE)) u_pick (.vec_i(elig), .found_o(pick_found), .idx_o(pick_idx));
  assign full = &vld;
  assign sel = rdy && pick_found && (!out_valid_q || out_grant);
  assign done = sel && alu_success;
  assign disp = issue_valid && free_found;
  assign byp_j = issue_qj_wait && cdb_valid && issue_qj == cdb_tag;
  assign byp_k = issue_qk_wait && cdb_valid && issue_qk == cdb_tag;
  assign alu_ready = sel;
  assign alu_op = sel ? ent_q[pick_idx].op : '0;
  assign alu_lv = sel ? ent_q[pick_idx].vj : '0;
  assign alu_rv = sel ? ent_q[pick_idx].vk : '0;
  assign out_valid = out_valid_q;
  assign out_tag = out_tag_q;
  assign out_value = out_value_q;
  always_comb begin
    ent_d = ent_q;
    out_valid_d = done ? True : (out_grant ? False : out_valid_q);
    out_tag_d = done ? ent_q[pick_idx].dest : out_tag_q;
    out_value_d = done ? alu_result : out_value_q;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (ent_q[i].valid && ent_q[i].wj && cdb_valid && ent_q[i].qj == cdb_tag) begin
        ent_d[i].wj = False;
        ent_d[i].vj = cdb_value;
      end
      if (ent_q[i].valid && ent_q[i].wk && cdb_valid && ent_q[i].qk == cdb_tag) begin
        ent_d[i].wk = False;
        ent_d[i].vk = cdb_value;
      end
      if (done && pick_idx == IW'(i)) ent_d[i].valid = False;
      if (disp && free_idx == IW'(i))
        ent_d[i] = '{valid: True, op: issue_op,
                     vj: byp_j ? cdb_value : issue_vj, vk: byp_k ? cdb_value : issue_vk,
                     wj: issue_qj_wait && !byp_j, wk: issue_qk_wait && !byp_k,
                     qj: issue_qj, qk: issue_qk, dest: issue_dest};
    end
  end
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
      out_valid_q <= 1'b0;
      out_tag_q <= '0;
      out_value_q <= '0;
    end else if (rdy) begin
      ent_q <= ent_d;
      out_valid_q <= out_valid_d;
      out_tag_q <= out_tag_d;
      out_value_q <= out_value_d;
    end
  end
endmodule

// File: tb/tb_alu_rs_scheduler.sv
// tb_alu_rs_scheduler: directed and random checks of the reservation station against a behavioural model
module tb_alu_rs_scheduler;
  import alu_rs_scheduler_pkg::*;
  localparam int N = 8;
  logic clk = 1'b0;
  logic rst, rdy, clear, issue_valid, issue_qj_wait, issue_qk_wait;
  logic [3:0] issue_op, issue_qj, issue_qk, issue_dest, cdb_tag, alu_op, out_tag;
  logic [31:0] issue_vj, issue_vk, cdb_value, alu_lv, alu_rv, alu_result, out_value;
  logic full, cdb_valid, alu_ready, alu_success, out_valid, out_grant;
  bit m_v [N];
  bit m_wj [N];
  bit m_wk [N];
  logic [3:0] m_op [N];
  logic [3:0] m_qj [N];
  logic [3:0] m_qk [N];
  logic [3:0] m_dst [N];
  logic [31:0] m_vj [N];
  logic [31:0] m_vk [N];
  bit m_ov;
  logic [3:0] m_ot;
  logic [31:0] m_oval;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  alu_rs_scheduler dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj_wait(issue_qj_wait), .issue_qk_wait(issue_qk_wait), .issue_qj(issue_qj),
    .issue_qk(issue_qk), .issue_dest(issue_dest), .full(full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .alu_ready(alu_ready), .alu_op(alu_op), .alu_lv(alu_lv), .alu_rv(alu_rv),
    .alu_result(alu_result), .alu_success(alu_success),
    .out_valid(out_valid), .out_tag(out_tag), .out_value(out_value), .out_grant(out_grant)
  );
  function automatic logic [31:0] alu_fn(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      Add:    return a + b;
      Minus:  return a - b;
      Less_S: return {31'd0, $signed(a) < $signed(b)};
      Less_U: return {31'd0, a < b};
      And:    return a & b;
      Or:     return a | b;
      Xor:    return a ^ b;
      Sll:    return a << b[4:0];
      Srl:    return a >> b[4:0];
      Sra:    return $unsigned($signed(a) >>> b[4:0]);
      Eq:     return {31'd0, a == b};
      Ne:     return {31'd0, a != b};
      default: return 32'd0;
    endcase
  endfunction
  assign alu_result = alu_fn(alu_op, alu_lv, alu_rv);
  function automatic int m_pick();
    for (int i = 0; i < N; i++) if (m_v[i] && !m_wj[i] && !m_wk[i]) return i;
    return -1;
  endfunction
  function automatic int m_free();
    for (int i = 0; i < N; i++) if (!m_v[i]) return i;
    return -1;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic settle();
    int e;
    bit s;
    #1;
    e = m_pick();
    s = rdy && e >= 0 && (!m_ov || out_grant);
    chk("full", full, {31'd0, m_free() < 0});
    chk("alu_ready", alu_ready, {31'd0, s});
    chk("alu_op", alu_op, s ? m_op[e] : 4'd0);
    chk("alu_lv", alu_lv, s ? m_vj[e] : 32'd0);
    chk("alu_rv", alu_rv, s ? m_vk[e] : 32'd0);
    chk("out_valid", out_valid, {31'd0, m_ov});
    chk("out_tag", out_tag, m_ot);
    chk("out_value", out_value, m_oval);
  endtask
  task automatic commit();
    int e, f;
    bit done;
    logic [31:0] res;
    if (rst || clear) begin
      for (int i = 0; i < N; i++) m_v[i] = 0;
      m_ov = 0;
      m_ot = 0;
      m_oval = 0;
    end else if (rdy) begin
      e = m_pick();
      f = m_free();
      done = e >= 0 && (!m_ov || out_grant) && alu_success;
      res = done ? alu_fn(m_op[e], m_vj[e], m_vk[e]) : 32'd0;
      for (int i = 0; i < N; i++) begin
        if (m_v[i] && m_wj[i] && cdb_valid && m_qj[i] == cdb_tag) begin m_wj[i] = 0; m_vj[i] = cdb_value; end
        if (m_v[i] && m_wk[i] && cdb_valid && m_qk[i] == cdb_tag) begin m_wk[i] = 0; m_vk[i] = cdb_value; end
      end
      if (done) m_v[e] = 0;
      if (issue_valid && f >= 0) begin
        m_v[f] = 1;
        m_op[f] = issue_op;
        m_qj[f] = issue_qj;
        m_qk[f] = issue_qk;
        m_dst[f] = issue_dest;
        m_wj[f] = issue_qj_wait && !(cdb_valid && issue_qj == cdb_tag);
        m_wk[f] = issue_qk_wait && !(cdb_valid && issue_qk == cdb_tag);
        m_vj[f] = (issue_qj_wait && !m_wj[f]) ? cdb_value : issue_vj;
        m_vk[f] = (issue_qk_wait && !m_wk[f]) ? cdb_value : issue_vk;
      end
      if (done) begin
        m_ov = 1;
        m_ot = m_dst[e];
        m_oval = res;
      end else if (out_grant) m_ov = 0;
    end
    @(negedge clk);
  endtask
  task automatic idle();
    rst = 0; clear = 0; rdy = 1; issue_valid = 0; issue_op = 0; issue_vj = 0; issue_vk = 0;
    issue_qj_wait = 0; issue_qk_wait = 0; issue_qj = 0; issue_qk = 0; issue_dest = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_value = 0; alu_success = 1; out_grant = 0;
  endtask
  task automatic disp(logic [3:0] op, logic [31:0] vj, logic [31:0] vk, logic wj, logic [3:0] qj,
                      logic wk, logic [3:0] qk, logic [3:0] dest);
    issue_valid = 1; issue_op = op; issue_vj = vj; issue_vk = vk;
    issue_qj_wait = wj; issue_qj = qj; issue_qk_wait = wk; issue_qk = qk; issue_dest = dest;
  endtask
  task automatic step();
    settle();
    commit();
  endtask
  initial begin
    idle();
    rst = 1;
    @(negedge clk);
    commit();
    idle(); settle();
    chk("rst_full", full, 0); chk("rst_out_valid", out_valid, 0); chk("rst_alu_ready", alu_ready, 0);
    commit();
    idle(); disp(Add, 5, 7, 0, 0, 0, 0, 3); step();
    idle(); settle();
    chk("add_ready", alu_ready, 1); chk("add_lv", alu_lv, 5); chk("add_rv", alu_rv, 7);
    commit();
    idle(); out_grant = 1; settle();
    chk("add_ov", out_valid, 1); chk("add_tag", out_tag, 3); chk("add_val", out_value, 12);
    commit();
    idle(); settle(); chk("add_ov_clr", out_valid, 0); commit();
    idle(); disp(Minus, 0, 1, 1, 9, 0, 0, 5); step();
    idle(); settle(); chk("wait_idle", alu_ready, 0); commit();
    idle(); cdb_valid = 1; cdb_tag = 9; cdb_value = 10; settle(); chk("wake_cycle", alu_ready, 0); commit();
    idle(); settle(); chk("woke_ready", alu_ready, 1); chk("woke_lv", alu_lv, 10); commit();
    idle(); out_grant = 1; settle(); chk("minus_val", out_value, 9); chk("minus_tag", out_tag, 5); commit();
    idle(); disp(Minus, 0, 1, 1, 9, 0, 0, 6); cdb_valid = 1; cdb_tag = 9; cdb_value = 10; step();
    idle(); settle(); chk("byp_ready", alu_ready, 1); chk("byp_lv", alu_lv, 10); commit();
    idle(); out_grant = 1; settle(); chk("byp_val", out_value, 9); commit();
    idle(); commit();
    for (int k = 0; k < N; k++) begin
      idle(); disp(Add, k, 0, 1, 15, 0, 0, 4'(k)); step();
    end
    idle(); disp(Add, 77, 0, 0, 0, 0, 0, 9); cdb_valid = 1; cdb_tag = 15; cdb_value = 1;
    settle(); chk("full_set", full, 1); commit();
    idle(); out_grant = 1; settle();
    chk("full_issue", alu_ready, 1); chk("full_lv", alu_lv, 1); chk("full_still", full, 1);
    commit();
    idle(); out_grant = 1; disp(Add, 100, 0, 0, 0, 0, 0, 10); settle(); chk("full_clr", full, 0); commit();
    idle(); out_grant = 1; settle(); chk("reuse_slot0", alu_lv, 100); commit();
    repeat (12) begin idle(); out_grant = 1; step(); end
    idle(); disp(Add, 1, 2, 0, 0, 0, 0, 1); step();
    idle(); disp(Add, 3, 4, 0, 0, 0, 0, 2); step();
    idle(); settle(); chk("hold_ready", alu_ready, 0); chk("hold_val", out_value, 3); commit();
    idle(); settle(); chk("hold_val2", out_value, 3); commit();
    idle(); out_grant = 1; settle(); chk("b2b_ready", alu_ready, 1); chk("b2b_lv", alu_lv, 3); commit();
    idle(); out_grant = 1; settle(); chk("b2b_val", out_value, 7); chk("b2b_tag", out_tag, 2); commit();
    idle(); out_grant = 1; step();
    idle(); disp(Add, 0, 5, 1, 4, 0, 0, 7); step();
    repeat (3) begin
      idle(); rdy = 0; cdb_valid = 1; cdb_tag = 4; cdb_value = 20; out_grant = 1;
      settle(); chk("stall_ready", alu_ready, 0); commit();
    end
    idle(); cdb_valid = 1; cdb_tag = 4; cdb_value = 20; settle(); chk("resume_wait", alu_ready, 0); commit();
    idle(); out_grant = 1; settle(); chk("resume_ready", alu_ready, 1); chk("resume_lv", alu_lv, 20); commit();
    idle(); out_grant = 1; settle(); chk("resume_val", out_value, 25); commit();
    idle(); disp(Add, 2, 2, 0, 0, 0, 0, 4); step();
    for (int k = 0; k < 3; k++) begin idle(); disp(Add, 1, 1, 1, 13, 0, 0, 4'(k)); step(); end
    idle(); rst = 1; settle(); chk("pre_rst_ov", out_valid, 1); commit();
    idle(); cdb_valid = 1; cdb_tag = 13; settle();
    chk("mid_rst_full", full, 0); chk("mid_rst_ov", out_valid, 0); chk("mid_rst_ready", alu_ready, 0);
    commit();
    idle(); settle(); chk("no_stale", alu_ready, 0); commit();
    for (int c = 0; c < 3000; c++) begin
      rst = $urandom_range(199) == 0;
      clear = $urandom_range(59) == 0;
      rdy = $urandom_range(7) != 0;
      issue_valid = $urandom_range(1);
      issue_op = 4'($urandom_range(11));
      issue_vj = $urandom;
      issue_vk = $urandom_range(3) == 0 ? 32'($urandom_range(40)) : $urandom;
      issue_qj_wait = $urandom_range(9) < 4;
      issue_qk_wait = $urandom_range(9) < 4;
      issue_qj = 4'($urandom_range(7));
      issue_qk = 4'($urandom_range(7));
      issue_dest = 4'($urandom);
      cdb_valid = $urandom_range(9) < 4;
      cdb_tag = 4'($urandom_range(7));
      cdb_value = $urandom;
      alu_success = $urandom_range(3) != 0;
      out_grant = $urandom_range(9) < 6;
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_rs_scheduler.md
Name: alu_rs_scheduler

Overview:
Reservation-station scheduler that shares the single combinational ALU among up to RS_SIZE dispatched integer ops in the out-of-order core. Holds operands or producer tags, wakes operands by snooping the common data bus (CDB), and issues one ready op per cycle to the ALU. Latches each ALU result into an output register that is held until the CDB arbiter grants it.

Parameters:
RS_SIZE, 8, number of station entries (power of 2, ≥2)
TAG_W, 4, ROB tag width
OP_W, 4, ALU op-code width (op codes from the shared constants file)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
rdy  in  1  global ready; when low, all state holds
clear  in  1  pipeline flush (mispredict)
issue_valid  in  1  dispatch request
issue_op  in  OP_W  ALU operation
issue_vj / issue_vk  in  32  operand values, used when not waiting
issue_qj_wait / issue_qk_wait  in  1  operand still awaits producer tag
issue_qj / issue_qk  in  TAG_W  producer tags
issue_dest  in  TAG_W  destination ROB tag
full  out  1  no free entry; dispatcher must not issue
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  broadcast tag
cdb_value  in  32  broadcast value
alu_ready  out  1  ALU request (ALU_ready)
alu_op  out  OP_W  ALU Op
alu_lv / alu_rv  out  32  ALU LV / RV
alu_result  in  32  ALU result
alu_success  in  1  ALU completion
out_valid  out  1  result pending for CDB
out_tag  out  TAG_W  result ROB tag
out_value  out  32  result value
out_grant  in  1  CDB arbiter accepts result this cycle

Behaviour:
- Clock is clk. Reset is synchronous, active-high, on rst. The rst and clear inputs have identical effect: all entries invalid, out_valid=0, out_tag=0, out_value=0. rst/clear override rdy and every same-cycle event.
- rdy=0: no register changes. alu_ready forced 0. out_valid held. out_grant ignored.
- full = AND of entry valid bits (registered state). A dispatch while full is ignored.
- Dispatch: on the edge with issue_valid && !full, the lowest-index free entry is written.
  - Same-cycle bypass: an operand marked waiting whose tag equals cdb_tag while cdb_valid=1 is stored as ready with cdb_value.
  - A slot freed on the same edge is not reused until the next cycle.
- Wakeup: each edge, every valid waiting operand with matching cdb_tag (cdb_valid=1) captures cdb_value and clears its wait flag. A single broadcast may wake both operands of one entry and operands in multiple entries.
- Eligibility: an entry is eligible when it is valid and both wait flags are 0 in the registered state. Wakeup therefore costs one cycle before issue.
- Select: the lowest-index eligible entry is chosen, gated by slot_free = !out_valid || out_grant.
  - When an entry is selected: alu_ready=1 and alu_op/alu_lv/alu_rv are driven from the entry, combinationally in the same cycle.
  - When none is selected: alu_ready=0 and the ALU inputs are 0.
- Completion: on an edge with alu_ready && alu_success:
  - out_valid←1, out_value←alu_result, out_tag←entry dest;
  - the entry is freed.
  - If alu_success=0, the entry stays and retries.
- Output: out_valid=1 is held, with stable tag and value, until a cycle with out_grant=1. That edge clears out_valid unless a new result loads on the same edge (back-to-back, no bubble).
- Latency: dispatch with both operands ready at edge T → alu_ready in cycle T+1 → out_valid from edge T+1 (visible in cycle T+2).
- Throughput: 1 op/cycle while out_grant stays 1.

Decomposition:
- Shared constants file: ALU op codes (`Add`, `Minus`, `Less_S`, ...), TAG_W, True/False.
- One sub-module, rs_lowest_one (parameter N): bit vector in → found, index out. It is instantiated twice: once for the free slot (on ~valid) and once for the issue pick (on eligible).

Test Plan:
- Reset mid-run with 3 valid entries and out_valid=1; hold rst 1 cycle → full=0, out_valid=0, alu_ready=0 next cycle; no stale issue afterwards.
- Dispatch `Add` vj=5, vk=7, dest=3, no waits → alu_ready cycle T+1 with lv=5, rv=7; out_valid=1, tag=3, value=12 in cycle T+2; out_grant=1 → out_valid=0.
- Dispatch `Minus` with qj_wait tag=9, vk=1; CDB tag=9 value=10 two cycles later → issue one cycle after broadcast, result 9. Repeat with CDB on the dispatch cycle → bypass captured, same latency as no-wait.
- Fill 8 entries → full=1; 9th issue_valid ignored; grant one result → full=0 next cycle; lowest freed slot reused.
- Hold out_grant=0 with 2 ready entries → exactly one result latched, alu_ready=0 afterwards, out_value stable; assert out_grant → second result appears on the very next cycle.
- rdy=0 for 3 cycles with CDB wakeup and issue pending → no state change; after rdy=1, behaviour resumes exactly as if no stall.
